// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL clock sequencer.
package pll_seq_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_e;

    // Bits needed to hold values 0..max_val (at least 1).
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clken_divider.sv
// Per-channel clock-enable divider: strobe every d+1 cycles, shadowed divisor
// reloaded on counter wrap (or immediately while the channel is held in reset).
module clken_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chan_rst,
    input  logic             wr,
    input  logic [DIV_W-1:0] val,
    output logic             clk_en
);

    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap   = (cnt == active);
    assign clk_en = !chan_rst && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            cnt    <= '0;
        end else begin
            if (wr) begin
                shadow <= val;
            end
            // A write landing on a wrap cycle waits for the next wrap.
            if (chan_rst) begin
                cnt    <= '0;
                active <= wr ? val : shadow;
            end else if (wrap) begin
                cnt    <= '0;
                active <= shadow;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_clock_sequencer.sv
// PLL reset/lock sequencer with ordered channel reset release and programmable
// clock-enable dividers. Define PLL_SEQ_RETRY_EN to re-lock after lock loss.
module pll_clock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH             = 3,
    parameter int DIV_W              = 8,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int RELEASE_GAP        = 4,
    parameter int SYNC_STAGES        = 2,
    localparam int SEL_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_lock_i,
    output logic                  pll_resetb_o,
    input  logic                  div_wr_i,
    input  logic [SEL_W-1:0]      div_sel_i,
    input  logic [DIV_W-1:0]      div_val_i,
    output logic [NUM_CH-1:0]     clk_en_o,
    output logic [NUM_CH-1:0]     rst_o,
    output logic                  ready_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o
);

    localparam int REL_LAST = (NUM_CH - 1) * RELEASE_GAP;
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (LOCK_STABLE_CYCLES > REL_LAST) ? LOCK_STABLE_CYCLES : REL_LAST;
    localparam int CNT_W    = cnt_width((MAX_A > MAX_B) ? MAX_A : MAX_B);

    localparam logic [CNT_W-1:0] RST_END    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_END     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_END    = CNT_W'(REL_LAST);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    state_e                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [NUM_CH-1:0]      rst_q, rst_d;
    logic [LOSS_CNT_W-1:0]  loss_cnt, loss_d;

    assign lock_s = lock_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_sync <= '0;
            state     <= PLL_RST;
            cnt       <= '0;
            rst_q     <= '1;
            loss_cnt  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock_i};
            state     <= state_d;
            cnt       <= cnt_d;
            rst_q     <= rst_d;
            loss_cnt  <= loss_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        rst_d   = rst_q;
        loss_d  = loss_cnt;
        unique case (state)
            PLL_RST: begin
                rst_d = '1;
                if (cnt == RST_END) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt == TO_END) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            end
            STABLE, RELEASE, RUN: begin
                if (!lock_s) begin
`ifdef PLL_SEQ_RETRY_EN
                    state_d = PLL_RST;
`else
                    state_d = FAULT;
`endif
                    cnt_d = '0;
                    rst_d = '1;
                    if (loss_cnt != '1) begin
                        loss_d = loss_cnt + 1'b1;
                    end
                end else if (state == STABLE) begin
                    if (cnt == STABLE_END) begin
                        state_d  = RELEASE;
                        cnt_d    = '0;
                        rst_d[0] = 1'b0;
                    end
                end else if (state == RELEASE) begin
                    // cnt tracks cycles since RELEASE entry; channel i drops at i*GAP.
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (32'(cnt) + 32'd1 >= i * 32'(RELEASE_GAP)) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                    if (cnt == REL_END) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt;
                end
            end
            FAULT: begin
                cnt_d = cnt;
                rst_d = '1;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
                rst_d   = '1;
            end
        endcase
    end

    assign pll_resetb_o    = (state != PLL_RST);
    assign ready_o         = (state == RUN);
    assign rst_o           = rst_q;
    assign lock_loss_cnt_o = loss_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_div
        clken_divider #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk      (clk),
            .reset    (reset),
            .chan_rst (rst_q[g]),
            .wr       (div_wr_i && (div_sel_i == SEL_W'(g))),
            .val      (div_val_i),
            .clk_en   (clk_en_o[g])
        );
    end

endmodule

// File: tb/tb_pll_clock_sequencer.sv
// Scoreboard bench for pll_clock_sequencer: stimulus schedules expected output
// values by cycle number; a negedge monitor pops and compares them.
module tb_pll_clock_sequencer;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pll_lock_i = 1'b0;
    logic              div_wr_i = 1'b0;
    logic [1:0]        div_sel_i = '0;
    logic [DIV_W-1:0]  div_val_i = '0;
    logic              pll_resetb_o;
    logic [NUM_CH-1:0] clk_en_o;
    logic [NUM_CH-1:0] rst_o;
    logic              ready_o;
    logic [7:0]        lock_loss_cnt_o;

    pll_clock_sequencer #(
        .NUM_CH             (NUM_CH),
        .DIV_W              (DIV_W),
        .PLL_RST_CYCLES     (16),
        .LOCK_STABLE_CYCLES (256),
        .LOCK_TIMEOUT       (4096),
        .RELEASE_GAP        (4),
        .SYNC_STAGES        (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_lock_i      (pll_lock_i),
        .pll_resetb_o    (pll_resetb_o),
        .div_wr_i        (div_wr_i),
        .div_sel_i       (div_sel_i),
        .div_val_i       (div_val_i),
        .clk_en_o        (clk_en_o),
        .rst_o           (rst_o),
        .ready_o         (ready_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_PRB = 0, S_RST = 1, S_RDY = 2, S_CEN = 3, S_LOSS = 4;

    typedef struct {
        int          t;
        int          sig;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int t, input int sig, input logic [31:0] v, input string nm);
        exp_t e;
        int   i;
        e.t = t; e.sig = sig; e.v = v; e.nm = nm;
        i = 0;
        while (i < sb.size() && sb[i].t <= t) i++;
        sb.insert(i, e);
    endtask

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_PRB:   return {31'd0, pll_resetb_o};
            S_RST:   return {29'd0, rst_o};
            S_RDY:   return {31'd0, ready_o};
            S_CEN:   return {29'd0, clk_en_o};
            default: return {24'd0, lock_loss_cnt_o};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].t <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.t != cyc) begin
                errors++;
                $display("FAIL %s: scheduled cycle %0d passed unchecked (now %0d)", e.nm, e.t, cyc);
            end else if (actual(e.sig) !== e.v) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %0h, expected %0h", e.nm, cyc, actual(e.sig), e.v);
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_reset_vals(input int t, input string tag);
        expect_at(t, S_PRB, 32'd0, {tag, "_prb"});
        expect_at(t, S_RST, 32'd7, {tag, "_rst"});
        expect_at(t, S_RDY, 32'd0, {tag, "_rdy"});
        expect_at(t, S_CEN, 32'd0, {tag, "_cen"});
        expect_at(t, S_LOSS, 32'd0, {tag, "_loss"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    localparam int R0 = 4;
    localparam int T  = R0 + 330;
    localparam int L  = T + 40;
    localparam int P  = L + 300;
    localparam int R1 = P + 3;
    localparam int R2 = R1 + 280;

    initial begin
        @(negedge clk);
        goto(2);

        // Reset state and power-up sequence (lock rises 50 cycles after reset falls).
        push_reset_vals(R0, "reset");
        expect_at(R0 + 15,  S_PRB, 32'd0, "prb_low_last");
        expect_at(R0 + 16,  S_PRB, 32'd1, "prb_release");
        expect_at(R0 + 308, S_RST, 32'd7, "rst_before_rel");
        expect_at(R0 + 308, S_CEN, 32'd0, "cen_before_rel");
        expect_at(R0 + 309, S_RST, 32'd6, "rst0_fall");
        expect_at(R0 + 309, S_CEN, 32'd1, "cen0_start");
        expect_at(R0 + 312, S_RST, 32'd6, "rst1_hold");
        expect_at(R0 + 313, S_RST, 32'd4, "rst1_fall");
        expect_at(R0 + 316, S_RST, 32'd4, "rst2_hold");
        expect_at(R0 + 317, S_RST, 32'd0, "rst2_fall");
        expect_at(R0 + 317, S_RDY, 32'd0, "ready_early");
        expect_at(R0 + 318, S_RDY, 32'd1, "ready_rise");
        expect_at(R0 + 318, S_CEN, 32'd7, "cen_all");
        expect_at(R0 + 318, S_LOSS, 32'd0, "loss_zero");

        // ch1 divisor 3 then 0 written mid-period; out-of-range select ignored.
        expect_at(T + 1, S_CEN, 32'd7, "div3_pre");
        for (int k = 2; k <= 12; k++)
            expect_at(T + k, S_CEN, ((k - 1) % 4 == 0) ? 32'd7 : 32'd5, "div3_period");
        for (int k = 13; k <= 16; k++)
            expect_at(T + k, S_CEN, 32'd7, "div0_const");
        for (int k = 21; k <= 30; k++)
            expect_at(T + k, S_CEN, 32'd7, "sel_oob_ignored");

        // One-cycle lock drop in RUN.
        expect_at(L + 2, S_RST, 32'd0, "loss_rst_before");
        expect_at(L + 2, S_RDY, 32'd1, "loss_rdy_before");
        expect_at(L + 2, S_LOSS, 32'd0, "loss_cnt_before");
        expect_at(L + 3, S_RST, 32'd7, "loss_rst_after");
        expect_at(L + 3, S_RDY, 32'd0, "loss_rdy_after");
        expect_at(L + 3, S_CEN, 32'd0, "loss_cen_after");
        expect_at(L + 3, S_LOSS, 32'd1, "loss_cnt_after");
`ifdef PLL_SEQ_RETRY_EN
        expect_at(L + 3,   S_PRB, 32'd0, "retry_prb_low");
        expect_at(L + 18,  S_PRB, 32'd0, "retry_prb_low_last");
        expect_at(L + 19,  S_PRB, 32'd1, "retry_prb_high");
        expect_at(L + 275, S_RST, 32'd7, "retry_rst_hold");
        expect_at(L + 276, S_RST, 32'd6, "retry_rst0_fall");
        expect_at(L + 285, S_RDY, 32'd1, "retry_ready");
        expect_at(L + 285, S_LOSS, 32'd1, "retry_loss_cnt");
`else
        expect_at(L + 3,   S_PRB, 32'd1, "fault_prb");
        expect_at(L + 100, S_PRB, 32'd1, "fault_prb_hold");
        expect_at(L + 100, S_RST, 32'd7, "fault_rst_hold");
        expect_at(L + 100, S_RDY, 32'd0, "fault_rdy_hold");
        expect_at(L + 100, S_CEN, 32'd0, "fault_cen_hold");
        expect_at(L + 290, S_LOSS, 32'd1, "fault_loss_cnt");
`endif

        goto(R0);
        reset = 1'b0;
        goto(R0 + 50);
        pll_lock_i = 1'b1;

        goto(T);
        div_wr_i = 1'b1; div_sel_i = 2'd1; div_val_i = 8'd3;
        goto(T + 1);
        div_wr_i = 1'b0;
        goto(T + 11);
        div_wr_i = 1'b1; div_sel_i = 2'd1; div_val_i = 8'd0;
        goto(T + 12);
        div_wr_i = 1'b0;
        goto(T + 20);
        div_wr_i = 1'b1; div_sel_i = 2'd3; div_val_i = 8'd5;
        goto(T + 21);
        div_wr_i = 1'b0; div_sel_i = 2'd0;

        goto(L);
        pll_lock_i = 1'b0;
        goto(L + 1);
        pll_lock_i = 1'b1;

        // Async reset during RELEASE with rst_o[0] already low.
        goto(P);
        reset = 1'b1;
        expect_at(R1 + 272, S_RST, 32'd7, "rel2_rst_hold");
        expect_at(R1 + 273, S_RST, 32'd6, "rel2_rst0_fall");
        expect_at(R1 + 274, S_RST, 32'd6, "rel2_mid");
        push_reset_vals(R1 + 275, "async_reset");
        goto(R1);
        reset = 1'b0;
        goto(R1 + 274);
        @(posedge clk);
        #2 reset = 1'b1;
        pll_lock_i = 1'b0;

        // Lock never arrives: PLL reset re-pulses every 16+4096 cycles.
        @(negedge clk);
        expect_at(R2 + 15,   S_PRB, 32'd0, "to_prb_low");
        expect_at(R2 + 16,   S_PRB, 32'd1, "to_prb_high");
        expect_at(R2 + 4111, S_PRB, 32'd1, "to_wait_last");
        expect_at(R2 + 4112, S_PRB, 32'd0, "to_repulse1");
        expect_at(R2 + 4127, S_PRB, 32'd0, "to_repulse1_last");
        expect_at(R2 + 4128, S_PRB, 32'd1, "to_repulse1_end");
        expect_at(R2 + 8223, S_PRB, 32'd1, "to_wait2_last");
        expect_at(R2 + 8224, S_PRB, 32'd0, "to_repulse2");
        expect_at(R2 + 8230, S_LOSS, 32'd0, "to_no_loss");
        expect_at(R2 + 8230, S_RST, 32'd7, "to_rst_held");
        goto(R2);
        reset = 1'b0;
        goto(R2 + 8240);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never compared", e.nm, e.t);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
